// File: rtl/sram_responder_if.sv
// sram_responder_if -- control/address bundle of the asynchronous SRAM port (rev 1.0).
// The 32-bit data bus stays a plain inout on the responder so tristate resolution stays at module level.
`default_nettype none

interface sram_responder_if;
  logic [19:0] ramAddr_i;
  logic        CE_n_i;
  logic        OE_n_i;
  logic        WE_n_i;
  logic [3:0]  be_n_i;

  modport master (output ramAddr_i, CE_n_i, OE_n_i, WE_n_i, be_n_i);
  modport slave  (input  ramAddr_i, CE_n_i, OE_n_i, WE_n_i, be_n_i);
endinterface

`default_nettype wire

// File: rtl/sram_responder.sv
// sram_responder -- SRAM slave with READ_LAT read latency and byte-lane write commit (rev 1.0).
// Define SRAM_RESP_CHECK_EN to build the sticky protocol checker and its err_o port.
`default_nettype none

module sram_responder #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input  wire logic        clk50,
  input  wire logic        rst,
  sram_responder_if.slave  bus,
  inout  wire       [31:0] data_io
`ifdef SRAM_RESP_CHECK_EN
  ,
  output logic             err_o
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RLAT   = 2'd1,
    RDRIVE = 2'd2,
    WHOLD  = 2'd3
  } state_t;

  localparam logic [1:0] LAT_RELOAD = 2'(READ_LAT - 1);

  logic [31:0]       mem [2**ADDR_W];
  state_t            state, state_nxt;
  logic [1:0]        lat_cnt, lat_cnt_nxt;
  logic [ADDR_W-1:0] addr, last_addr, rd_addr, hold_addr;
  logic [31:0]       hold_data, rd_data;
  logic [3:0]        hold_be;
  logic              rd_req, wr_req, addr_chg;
  logic              capture, commit, drive_en;

  assign addr     = bus.ramAddr_i[ADDR_W-1:0];
  assign rd_req   = !bus.CE_n_i && !bus.OE_n_i && bus.WE_n_i;
  assign wr_req   = !bus.CE_n_i && !bus.WE_n_i;
  assign addr_chg = (addr != last_addr);

  if (ADDR_W < 20) begin : g_unused_addr
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.ramAddr_i[19:ADDR_W];
  end

  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    capture     = 1'b0;
    commit      = 1'b0;
    case (state)
      IDLE, RLAT: begin
        if (wr_req) begin
          state_nxt = WHOLD;
          capture   = 1'b1;
        end else if (rd_req) begin
          if (state == IDLE || addr_chg) begin
            lat_cnt_nxt = LAT_RELOAD;
            state_nxt   = (READ_LAT == 1) ? RDRIVE : RLAT;
          end else if (lat_cnt <= 2'd1) begin
            lat_cnt_nxt = 2'd0;
            state_nxt   = RDRIVE;
          end else begin
            lat_cnt_nxt = lat_cnt - 2'd1;
          end
        end else begin
          lat_cnt_nxt = 2'd0;
          state_nxt   = IDLE;
        end
      end
      RDRIVE: begin
        if (wr_req) begin
          state_nxt = WHOLD;
          capture   = 1'b1;
        end else if (rd_req) begin
          // With READ_LAT=1 the registered read address alone makes data follow one cycle later.
          if (addr_chg && READ_LAT > 1) begin
            lat_cnt_nxt = LAT_RELOAD;
            state_nxt   = RLAT;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WHOLD: begin
        if (wr_req) begin
          capture = 1'b1;
        end else begin
          commit = 1'b1;
          if (rd_req) begin
            lat_cnt_nxt = LAT_RELOAD;
            state_nxt   = RLAT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (!rst) begin
      state     <= IDLE;
      lat_cnt   <= 2'd0;
      last_addr <= '0;
      rd_addr   <= '0;
      hold_addr <= '0;
      hold_data <= '0;
      hold_be   <= 4'h0;
    end else begin
      state     <= state_nxt;
      lat_cnt   <= lat_cnt_nxt;
      last_addr <= addr;
      if (rd_req) rd_addr <= addr;
      if (capture) begin
        hold_addr <= addr;
        hold_data <= data_io;
        hold_be   <= bus.be_n_i;
      end
    end
  end

  // Memory has no reset; a commit coinciding with reset is dropped.
  always_ff @(posedge clk50) begin
    if (rst && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (!hold_be[i]) mem[hold_addr][8*i +: 8] <= hold_data[8*i +: 8];
      end
    end
  end

  // Reading the array after the commit edge gives write-then-read forwarding for free.
  assign rd_data  = mem[rd_addr];
  assign drive_en = (state == RDRIVE) && bus.WE_n_i;
  assign data_io  = drive_en ? rd_data : 32'bz;

`ifdef SRAM_RESP_CHECK_EN
  logic [3:0] last_be;
  logic       last_we_n;
  logic       proto_err;

  assign proto_err = (state == WHOLD && addr_chg)
                   || (!bus.WE_n_i && bus.CE_n_i)
                   || (!bus.WE_n_i && !last_we_n && bus.be_n_i != last_be);

  always_ff @(posedge clk50) begin
    if (!rst) begin
      err_o     <= 1'b0;
      last_be   <= 4'hF;
      last_we_n <= 1'b1;
    end else begin
      if (proto_err) err_o <= 1'b1;
      last_be   <= bus.be_n_i;
      last_we_n <= bus.WE_n_i;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_responder.sv
// tb_sram_responder -- directed checks of sram_responder with READ_LAT=3.
// Weak pull-ups make an undriven data bus read as all ones.
`default_nettype none

module tb_sram_responder;
  localparam int          LAT = 3;
  localparam logic [31:0] ZV  = 32'hFFFF_FFFF;

  logic        clk50 = 1'b0;
  logic        rst;
  wire  [31:0] data_io;
  logic [31:0] drv_data;
  logic        drv_en;
  int          checks = 0;
  int          fails  = 0;
`ifdef SRAM_RESP_CHECK_EN
  wire         err_o;
`endif

  sram_responder_if bus();

  assign data_io = drv_en ? drv_data : 32'bz;

  for (genvar i = 0; i < 32; i++) begin : g_pull
    pullup (data_io[i]);
  end

  sram_responder #(.ADDR_W(10), .READ_LAT(LAT)) dut (
    .clk50   (clk50),
    .rst     (rst),
    .bus     (bus),
    .data_io (data_io)
`ifdef SRAM_RESP_CHECK_EN
    ,
    .err_o   (err_o)
`endif
  );

  always #5 clk50 = ~clk50;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.CE_n_i = 1'b1;
    bus.OE_n_i = 1'b1;
    bus.WE_n_i = 1'b1;
    bus.be_n_i = 4'hF;
    drv_en     = 1'b0;
  endtask

  task automatic write_word(input logic [19:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.ramAddr_i = a;
    bus.be_n_i    = be;
    bus.CE_n_i    = 1'b0;
    bus.OE_n_i    = 1'b1;
    bus.WE_n_i    = 1'b0;
    drv_data      = d;
    drv_en        = 1'b1;
    tick();
    bus_idle();
    tick();
  endtask

  task automatic read_word(input logic [19:0] a, input logic [31:0] exp, input string tag);
    bus.ramAddr_i = a;
    bus.CE_n_i    = 1'b0;
    bus.OE_n_i    = 1'b0;
    bus.WE_n_i    = 1'b1;
    repeat (LAT - 1) tick();
    chk({tag, "_lat"}, data_io, ZV);
    tick();
    chk(tag, data_io, exp);
    bus.OE_n_i = 1'b1;
    tick();
    chk({tag, "_z"}, data_io, ZV);
    bus_idle();
  endtask

  initial begin
    bus_idle();
    bus.ramAddr_i = 20'h0;
    drv_data      = 32'h0;
    rst           = 1'b0;
    repeat (2) tick();
    chk("reset_z", data_io, ZV);
`ifdef SRAM_RESP_CHECK_EN
    chk("reset_err", {31'b0, err_o}, 32'd0);
`endif
    rst = 1'b1;
    tick();

    write_word(20'h00005, 32'hDEADBEEF, 4'h0);
    read_word(20'h00005, 32'hDEADBEEF, "word_rd");
    read_word(20'h40005, 32'hDEADBEEF, "upper_ignored");

    write_word(20'h3, 32'h11223344, 4'h0);
    read_word(20'h3, 32'h11223344, "preload");
    write_word(20'h3, 32'h000000AA, 4'hE);
    read_word(20'h3, 32'h112233AA, "byte0");
    write_word(20'h3, 32'h0000BBCC, 4'hC);
    read_word(20'h3, 32'h1122BBCC, "half0");
    write_word(20'h3, 32'hFFFFFFFF, 4'hF);
    read_word(20'h3, 32'h1122BBCC, "be_none");
    write_word(20'h3, 32'h99000000, 4'h7);
    read_word(20'h3, 32'h9922BBCC, "byte3");

    // Read phase for one cycle, then the initiator turns the bus around for a write.
    write_word(20'h10, 32'h12345678, 4'h0);
    bus.ramAddr_i = 20'h10;
    bus.CE_n_i = 1'b0; bus.OE_n_i = 1'b0; bus.WE_n_i = 1'b1;
    tick();
    bus.WE_n_i = 1'b0; bus.be_n_i = 4'h0; drv_data = 32'h5A5A5A5A; drv_en = 1'b1;
    #1 chk("turn_wr0", data_io, 32'h5A5A5A5A);
    tick();
    chk("turn_wr1", data_io, 32'h5A5A5A5A);
    bus.WE_n_i = 1'b1; bus.be_n_i = 4'hF; drv_en = 1'b0;
    tick();
    repeat (LAT - 2) tick();
    chk("turn_lat", data_io, ZV);
    tick();
    chk("turn_rd", data_io, 32'h5A5A5A5A);
    bus.WE_n_i = 1'b0;
    #1 chk("we_gate", data_io, ZV);
    bus.WE_n_i = 1'b1;
    #1 chk("we_regate", data_io, 32'h5A5A5A5A);
    bus.OE_n_i = 1'b1;
    tick();
    chk("turn_z", data_io, ZV);
    bus_idle();

    write_word(20'h7, 32'h00000000, 4'h0);
    bus.ramAddr_i = 20'h7;
    bus.CE_n_i = 1'b0; bus.WE_n_i = 1'b0; bus.be_n_i = 4'h0;
    drv_data = 32'hFFFFFFFF; drv_en = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus_idle();
    tick();
    chk("rst_wr_z", data_io, ZV);
    read_word(20'h7, 32'h00000000, "rst_wr_discard");

    write_word(20'h1, 32'h000000A1, 4'h0);
    write_word(20'h2, 32'h000000B2, 4'h0);
    bus.ramAddr_i = 20'h1;
    bus.CE_n_i = 1'b0; bus.OE_n_i = 1'b0; bus.WE_n_i = 1'b1;
    repeat (2) tick();
    chk("sw_c0", data_io, ZV);
    bus.ramAddr_i = 20'h2;
    tick();
    chk("sw_c1", data_io, ZV);
    tick();
    chk("sw_c2", data_io, ZV);
    tick();
    chk("sw_data", data_io, 32'h000000B2);
    bus.ramAddr_i = 20'h1;
    tick();
    chk("rdchg_c1", data_io, ZV);
    tick();
    chk("rdchg_c2", data_io, ZV);
    tick();
    chk("rdchg_data", data_io, 32'h000000A1);
    bus.OE_n_i = 1'b1;
    tick();
    bus_idle();

    // Deselected chip: no write and no drive whatever the other strobes do.
    bus.CE_n_i = 1'b1; bus.OE_n_i = 1'b0; bus.WE_n_i = 1'b0; bus.be_n_i = 4'h0;
    bus.ramAddr_i = 20'h5; drv_data = 32'h77777777; drv_en = 1'b1;
    repeat (3) tick();
    chk("ce_off_bus", data_io, 32'h77777777);
    bus_idle();
    tick();
    read_word(20'h5, 32'hDEADBEEF, "ce_off_nowrite");

`ifdef SRAM_RESP_CHECK_EN
    chk("err_we_no_ce", {31'b0, err_o}, 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("err_cleared", {31'b0, err_o}, 32'd0);
    bus.ramAddr_i = 20'h9;
    bus.CE_n_i = 1'b0; bus.WE_n_i = 1'b0; bus.be_n_i = 4'h0;
    drv_data = 32'h0; drv_en = 1'b1;
    tick();
    chk("err_wr_ok", {31'b0, err_o}, 32'd0);
    bus.ramAddr_i = 20'hA;
    tick();
    chk("err_addr_chg", {31'b0, err_o}, 32'd1);
    bus_idle();
    repeat (2) tick();
    chk("err_sticky", {31'b0, err_o}, 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("err_rst", {31'b0, err_o}, 32'd0);
    bus.CE_n_i = 1'b0; bus.WE_n_i = 1'b0; bus.be_n_i = 4'h0; drv_en = 1'b1;
    tick();
    bus.be_n_i = 4'h3;
    tick();
    chk("err_be_chg", {31'b0, err_o}, 32'd1);
    bus_idle();
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
